// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// mem_arbiter
// Arbitrates an instruction-fetch and a load/store requester onto one
// single-port byte RAM with registered read; range-checks each access.
// Revision: 1.0 - initial release
// =============================================================================
module mem_arbiter #(
   parameter int MEM_BYTES    = 2048,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        I_clk,
   input  logic        I_reset_n,
   input  logic        I_if_req,
   input  logic [15:0] I_if_addr,
   output logic        O_if_ack,
   output logic [15:0] O_if_data,
   output logic        O_if_err,
   input  logic        I_ls_req,
   input  logic        I_ls_write,
   input  logic [1:0]  I_ls_size,
   input  logic [15:0] I_ls_addr,
   input  logic [15:0] I_ls_data,
   output logic        O_ls_ack,
   output logic [15:0] O_ls_data,
   output logic        O_ls_err,
   output logic        O_ram_enable,
   output logic        O_ram_write,
   output logic [1:0]  O_ram_size,
   output logic [15:0] O_ram_addr,
   output logic [15:0] O_ram_data,
   input  logic [15:0] I_ram_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [16:0]      c_mem_limit = 17'(MEM_BYTES);
   localparam logic [CNT_W-1:0] c_starve    = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] c_cnt_max   = '1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ls_owner_q, ls_owner_d;
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic [15:0]       addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              err_q, err_d;

   logic              w_ls_win;
   logic [1:0]        w_sel_size;
   logic [15:0]       w_sel_addr;
   logic [16:0]       w_addr_ext;
   logic              w_legal;
   logic [15:0]       w_rdata;

   // Fetch is forced once load/store has won STARVE_LIMIT times in a row over it.
   assign w_ls_win   = I_ls_req && !(I_if_req && (cnt_q == c_starve));
   assign w_sel_size = w_ls_win ? I_ls_size : 2'd2;
   assign w_sel_addr = w_ls_win ? I_ls_addr : I_if_addr;
   assign w_addr_ext = {1'b0, w_sel_addr};
   assign w_legal    = ((w_sel_size == 2'd1) || (w_sel_size == 2'd2))
                       && (w_addr_ext < c_mem_limit)
                       && ((w_sel_size != 2'd2) || ((w_addr_ext + 17'd1) < c_mem_limit));

   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ls_owner_q <= 1'b0;
         write_q    <= 1'b0;
         size_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ls_owner_q <= ls_owner_d;
         write_q    <= write_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ls_owner_d   = ls_owner_q;
      write_d      = write_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      w_rdata      = I_ram_data;
      O_if_ack     = 1'b0;
      O_if_data    = '0;
      O_if_err     = 1'b0;
      O_ls_ack     = 1'b0;
      O_ls_data    = '0;
      O_ls_err     = 1'b0;
      O_ram_enable = 1'b0;
      O_ram_write  = 1'b0;
      O_ram_size   = size_q;
      O_ram_addr   = addr_q;
      O_ram_data   = wdata_q;

      case (state_q)
         IDLE: begin
            if (I_if_req || I_ls_req) begin
               ls_owner_d = w_ls_win;
               write_d    = w_ls_win ? I_ls_write : 1'b0;
               size_d     = w_sel_size;
               addr_d     = w_sel_addr;
               wdata_d    = w_ls_win ? I_ls_data : 16'h0000;
               err_d      = !w_legal;
               state_d    = w_legal ? ACCESS : RESP;
               if (w_ls_win && I_if_req) begin
                  cnt_d = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = '0;
               end
            end
         end
         ACCESS: begin
            O_ram_enable = 1'b1;
            O_ram_write  = write_q;
            state_d      = RESP;
         end
         RESP: begin
            if (write_q || err_q) begin
               w_rdata = '0;
            end else if (ls_owner_q && (size_q == 2'd1)) begin
               w_rdata[15:8] = 8'h00;
            end
            if (ls_owner_q) begin
               O_ls_ack  = 1'b1;
               O_ls_data = w_rdata;
               O_ls_err  = err_q;
            end else begin
               O_if_ack  = 1'b1;
               O_if_data = w_rdata;
               O_if_err  = err_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_arbiter
// Self-checking bench: RAM model, transaction-level arbitration/data model.
// Revision: 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int MEM_BYTES    = 2048;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_ack, if_err;
   logic [15:0] if_addr, if_data;
   logic        ls_req, ls_write, ls_ack, ls_err;
   logic [1:0]  ls_size;
   logic [15:0] ls_addr, ls_wdata, ls_rdata;
   logic        ram_en, ram_we;
   logic [1:0]  ram_size;
   logic [15:0] ram_addr, ram_wdata, ram_rdata;

   logic        bd_en;
   logic [15:0] bd_addr;
   logic [7:0]  bd_data;
   logic [7:0]  ram_mem [0:65535];
   logic [7:0]  ref_mem [0:MEM_BYTES-1];

   int n_cmp = 0;
   int n_bad = 0;
   int m_run = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
      .I_clk(clk), .I_reset_n(rst_n),
      .I_if_req(if_req), .I_if_addr(if_addr),
      .O_if_ack(if_ack), .O_if_data(if_data), .O_if_err(if_err),
      .I_ls_req(ls_req), .I_ls_write(ls_write), .I_ls_size(ls_size),
      .I_ls_addr(ls_addr), .I_ls_data(ls_wdata),
      .O_ls_ack(ls_ack), .O_ls_data(ls_rdata), .O_ls_err(ls_err),
      .O_ram_enable(ram_en), .O_ram_write(ram_we), .O_ram_size(ram_size),
      .O_ram_addr(ram_addr), .O_ram_data(ram_wdata), .I_ram_data(ram_rdata)
   );

   // Single-port RAM, little-endian halfwords, registered read; backdoor for preload.
   always @(posedge clk) begin
      if (bd_en) begin
         ram_mem[bd_addr] <= bd_data;
      end else if (ram_en) begin
         if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata[7:0];
            if (ram_size == 2'd2) ram_mem[ram_addr + 16'd1] <= ram_wdata[15:8];
         end else begin
            ram_rdata <= {ram_mem[ram_addr + 16'd1], ram_mem[ram_addr]};
         end
      end
   end

   task automatic drive_if(input bit req, input logic [15:0] a);
      if_req  = req;
      if_addr = a;
   endtask

   task automatic drive_ls(input bit req, input bit w, input logic [1:0] sz,
                           input logic [15:0] a, input logic [15:0] d);
      ls_req   = req;
      ls_write = w;
      ls_size  = sz;
      ls_addr  = a;
      ls_wdata = d;
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      bd_en   = 1'b1;
      bd_addr = a;
      bd_data = d;
      ref_mem[a] = d;
      @(posedge clk);
      @(negedge clk);
      bd_en = 1'b0;
   endtask

   // Reference arbitration: LS preferred unless IF has lost STARVE_LIMIT times in a row.
   task automatic model_grant(input bit ifp, input bit lsp, output bit ls_wins);
      ls_wins = lsp && !(ifp && m_run >= STARVE_LIMIT);
      if (ls_wins && ifp) m_run = (m_run < STARVE_LIMIT) ? m_run + 1 : m_run;
      else m_run = 0;
   endtask

   // Expected {latency, if_ack, ls_ack, if_err, ls_err, if_data, ls_data}.
   function automatic logic [43:0] exp_res(input bit is_ls, input bit wr,
                                           input logic [1:0] sz, input logic [15:0] a);
      int ai = int'(a);
      int nb = is_ls ? int'(sz) : 2;
      bit legal;
      logic [15:0] d = 16'h0000;
      legal = (nb == 1 || nb == 2) && (ai + nb <= MEM_BYTES);
      if (legal && !wr) d = (nb == 1) ? {8'h00, ref_mem[ai]} : {ref_mem[ai+1], ref_mem[ai]};
      return {legal ? 8'd2 : 8'd1, !is_ls, is_ls, !legal && !is_ls, !legal && is_ls,
              is_ls ? 16'h0000 : d, is_ls ? d : 16'h0000};
   endfunction

   task automatic model_write(input logic [1:0] sz, input logic [15:0] a, input logic [15:0] d);
      ref_mem[a] = d[7:0];
      if (sz == 2'd2) ref_mem[a + 16'd1] = d[15:8];
   endtask

   function automatic logic [71:0] all_outs();
      return {if_ack, if_data, if_err, ls_ack, ls_rdata, ls_err,
              ram_en, ram_we, ram_size, ram_addr, ram_wdata};
   endfunction

   // Starting at an IDLE negedge with requests applied, wait (bounded) for an ack,
   // then step to the following IDLE negedge. Latency 0 means no ack was seen.
   task automatic observe(output logic [43:0] res, output bit en_seen, output bit dual);
      int lat = 0;
      logic ia = 1'b0, la = 1'b0, ie = 1'b0, le = 1'b0;
      logic [15:0] id = 16'h0000, ld = 16'h0000;
      en_seen = 1'b0;
      dual    = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ram_en) en_seen = 1'b1;
         if (if_ack && ls_ack) dual = 1'b1;
         if (if_ack || ls_ack) begin
            lat = k; ia = if_ack; la = ls_ack; ie = if_err; le = ls_err;
            id = if_data; ld = ls_rdata;
            break;
         end
      end
      res = {8'(lat), ia, la, ie, le, id, ld};
      if (lat != 0) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (all_outs() !== 72'h0) begin
         n_bad++; $display("FAIL reset_idle: outputs=%h want 0", all_outs());
      end
      drive_if(1'b1, 16'h0004);
      drive_ls(1'b1, 1'b1, 2'd2, 16'h0010, 16'hFFFF);
      @(posedge clk); @(posedge clk); #1;
      n_cmp++;
      if (all_outs() !== 72'h0) begin
         n_bad++; $display("FAIL reset_with_req: outputs=%h want 0", all_outs());
      end
      drive_if(1'b0, 16'h0000);
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      m_run = 0;
   endtask

   task automatic test_if_fetch();
      logic [43:0] res, want;
      bit en, dual, w;
      poke(16'h0000, 8'h00); poke(16'h0001, 8'h80);
      poke(16'h0002, 8'h00); poke(16'h0003, 8'h8c);
      drive_if(1'b1, 16'h0000);
      model_grant(1'b1, 1'b0, w);
      want = exp_res(1'b0, 1'b0, 2'd2, 16'h0000);
      observe(res, en, dual);
      n_cmp++;
      if (res !== want) begin
         n_bad++; $display("FAIL if_fetch_0: got %h want %h (lat,ifa,lsa,ife,lse,ifd,lsd)", res, want);
      end
      n_cmp++;
      if (res[31:16] !== 16'h8000 || en !== 1'b1) begin
         n_bad++; $display("FAIL if_fetch_0_data: data=%h en=%b want 8000 en=1", res[31:16], en);
      end
      drive_if(1'b1, 16'h0002);
      model_grant(1'b1, 1'b0, w);
      want = exp_res(1'b0, 1'b0, 2'd2, 16'h0002);
      observe(res, en, dual);
      n_cmp++;
      if (res !== want || res[31:16] !== 16'h8c00) begin
         n_bad++; $display("FAIL if_fetch_2: got %h want %h (data 8c00)", res, want);
      end
      drive_if(1'b0, 16'h0000);
   endtask

   task automatic test_ls_rw();
      logic [43:0] res, want;
      bit en, dual, w;
      drive_ls(1'b1, 1'b1, 2'd2, 16'h0100, 16'hBEEF);
      model_grant(1'b0, 1'b1, w);
      want = exp_res(1'b1, 1'b1, 2'd2, 16'h0100);
      observe(res, en, dual);
      model_write(2'd2, 16'h0100, 16'hBEEF);
      n_cmp++;
      if (res !== want) begin
         n_bad++; $display("FAIL ls_write16: got %h want %h", res, want);
      end
      drive_ls(1'b1, 1'b0, 2'd1, 16'h0101, 16'h0000);
      model_grant(1'b0, 1'b1, w);
      want = exp_res(1'b1, 1'b0, 2'd1, 16'h0101);
      observe(res, en, dual);
      n_cmp++;
      if (res !== want || res[15:0] !== 16'h00BE) begin
         n_bad++; $display("FAIL ls_read8: got %h want %h (data 00be)", res, want);
      end
      drive_ls(1'b1, 1'b0, 2'd2, 16'h0100, 16'h0000);
      model_grant(1'b0, 1'b1, w);
      want = exp_res(1'b1, 1'b0, 2'd2, 16'h0100);
      observe(res, en, dual);
      n_cmp++;
      if (res !== want || res[15:0] !== 16'hBEEF) begin
         n_bad++; $display("FAIL ls_read16: got %h want %h (data beef)", res, want);
      end
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
   endtask

   task automatic test_simultaneous();
      logic [43:0] res, want;
      bit en, dual, w;
      drive_if(1'b1, 16'h0010);
      drive_ls(1'b1, 1'b0, 2'd2, 16'h0100, 16'h0000);
      model_grant(1'b1, 1'b1, w);
      want = w ? exp_res(1'b1, 1'b0, 2'd2, 16'h0100) : exp_res(1'b0, 1'b0, 2'd2, 16'h0010);
      observe(res, en, dual);
      n_cmp++;
      if (res !== want || dual) begin
         n_bad++; $display("FAIL simul_first: got %h dual=%b want %h dual=0", res, dual, want);
      end
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
      model_grant(1'b1, 1'b0, w);
      want = exp_res(1'b0, 1'b0, 2'd2, 16'h0010);
      observe(res, en, dual);
      n_cmp++;
      if (res !== want || dual) begin
         n_bad++; $display("FAIL simul_second: got %h dual=%b want %h dual=0", res, dual, want);
      end
      drive_if(1'b0, 16'h0000);
   endtask

   task automatic test_starvation();
      logic [43:0] res, want;
      logic [15:0] a;
      bit en, dual, w;
      int if_wins = 0;
      drive_if(1'b1, 16'h0040);
      a = 16'($urandom_range(0, MEM_BYTES - 2));
      for (int r = 0; r < 10; r++) begin
         drive_ls(1'b1, 1'b0, 2'd2, a, 16'h0000);
         model_grant(1'b1, 1'b1, w);
         want = w ? exp_res(1'b1, 1'b0, 2'd2, a) : exp_res(1'b0, 1'b0, 2'd2, 16'h0040);
         observe(res, en, dual);
         n_cmp++;
         if (res !== want) begin
            n_bad++; $display("FAIL starve_round_%0d: got %h want %h", r, res, want);
         end
         if (res[35]) if_wins++;
         if (w) a = 16'($urandom_range(0, MEM_BYTES - 2));
      end
      n_cmp++;
      if (if_wins != 2) begin
         n_bad++; $display("FAIL starve_if_count: got %0d want 2", if_wins);
      end
      drive_if(1'b0, 16'h0000);
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
   endtask

   task automatic test_errors();
      bit          c_ls [3] = '{1'b1, 1'b1, 1'b0};
      logic [1:0]  c_sz [3] = '{2'd2, 2'd3, 2'd2};
      logic [15:0] c_a  [3] = '{16'h07FF, 16'h0000, 16'h0800};
      logic [43:0] res, want;
      bit en, dual, w;
      for (int i = 0; i < 3; i++) begin
         drive_if(!c_ls[i], c_a[i]);
         drive_ls(c_ls[i], 1'b0, c_sz[i], c_a[i], 16'h0000);
         model_grant(!c_ls[i], c_ls[i], w);
         want = exp_res(c_ls[i], 1'b0, c_sz[i], c_a[i]);
         observe(res, en, dual);
         n_cmp++;
         if (res !== want) begin
            n_bad++; $display("FAIL err_case_%0d: got %h want %h", i, res, want);
         end
         n_cmp++;
         if (en !== 1'b0) begin
            n_bad++; $display("FAIL err_case_%0d_ram_en: got %b want 0", i, en);
         end
      end
      drive_if(1'b0, 16'h0000);
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
   endtask

   task automatic test_reset_access();
      logic [43:0] res, want;
      bit en, dual, w;
      poke(16'h0200, 8'hA5);
      poke(16'h0201, 8'h5A);
      drive_ls(1'b1, 1'b1, 2'd2, 16'h0200, 16'h1234);
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1) begin
         n_bad++; $display("FAIL rst_access_pre: en=%b we=%b want 1 1", ram_en, ram_we);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (all_outs() !== 72'h0) begin
         n_bad++; $display("FAIL rst_access_now: outputs=%h want 0", all_outs());
      end
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (all_outs() !== 72'h0) begin
         n_bad++; $display("FAIL rst_access_hold: outputs=%h want 0", all_outs());
      end
      rst_n = 1'b1;
      m_run = 0;
      drive_ls(1'b1, 1'b0, 2'd2, 16'h0200, 16'h0000);
      model_grant(1'b0, 1'b1, w);
      want = exp_res(1'b1, 1'b0, 2'd2, 16'h0200);
      observe(res, en, dual);
      n_cmp++;
      if (res !== want || res[15:0] !== 16'h5AA5) begin
         n_bad++; $display("FAIL rst_access_readback: got %h want %h (data 5aa5)", res, want);
      end
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
   endtask

   function automatic logic [15:0] rand_addr();
      int p = int'($urandom_range(0, 99));
      if (p < 6)  return 16'h07FF;
      if (p < 10) return 16'($urandom_range(MEM_BYTES, 65535));
      if (p < 55) return 16'($urandom_range(MEM_BYTES - 64, MEM_BYTES - 1));
      return 16'($urandom_range(0, MEM_BYTES - 1));
   endfunction

   function automatic logic [1:0] rand_size();
      int p = int'($urandom_range(0, 99));
      if (p < 5)  return 2'd0;
      if (p < 10) return 2'd3;
      if (p < 50) return 2'd1;
      return 2'd2;
   endfunction

   task automatic test_random();
      logic [43:0] res, want;
      bit en, dual, w;
      bit if_p = 1'b0, ls_p = 1'b0, ls_w = 1'b0;
      logic [15:0] if_a = 16'h0, ls_a = 16'h0, ls_d = 16'h0;
      logic [1:0]  ls_sz = 2'd0;
      for (int it = 0; it < 300; it++) begin
         if (!if_p && $urandom_range(0, 2) != 0) begin
            if_p = 1'b1; if_a = rand_addr();
         end
         if (!ls_p && $urandom_range(0, 2) != 0) begin
            ls_p = 1'b1; ls_w = 1'($urandom_range(0, 1)); ls_sz = rand_size();
            ls_a = rand_addr(); ls_d = 16'($urandom);
         end
         drive_if(if_p, if_a);
         drive_ls(ls_p, ls_w, ls_sz, ls_a, ls_d);
         if (!if_p && !ls_p) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({if_ack, ls_ack, ram_en} !== 3'b000) begin
               n_bad++; $display("FAIL rnd_idle_%0d: ack/en=%b want 000", it, {if_ack, ls_ack, ram_en});
            end
            continue;
         end
         model_grant(if_p, ls_p, w);
         want = w ? exp_res(1'b1, ls_w, ls_sz, ls_a) : exp_res(1'b0, 1'b0, 2'd2, if_a);
         observe(res, en, dual);
         n_cmp++;
         if (res !== want || dual) begin
            n_bad++; $display("FAIL rnd_%0d: got %h dual=%b want %h", it, res, dual, want);
         end
         n_cmp++;
         if (en !== (want[43:36] == 8'd2)) begin
            n_bad++; $display("FAIL rnd_%0d_ram_en: got %b want %b", it, en, want[43:36] == 8'd2);
         end
         if (w) begin
            if (ls_w && want[43:36] == 8'd2) model_write(ls_sz, ls_a, ls_d);
            ls_p = 1'b0;
         end else begin
            if_p = 1'b0;
         end
      end
      drive_if(1'b0, 16'h0000);
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bd_en = 1'b0;
      bd_addr = 16'h0;
      bd_data = 8'h0;
      drive_if(1'b0, 16'h0000);
      drive_ls(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
      @(negedge clk);
      for (int a = 0; a < MEM_BYTES; a++) poke(16'(a), 8'($urandom));
      test_reset();
      test_if_fetch();
      test_ls_rw();
      test_simultaneous();
      test_starvation();
      test_errors();
      test_reset_access();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
